pio_clkdiv_multi: RTL and testbench

PIO_CLKDIV_MULTI -- requirements
Module: pio_clkdiv_multi

---
 rtl/pio_clkdiv_multi.sv | 62 ++++++
 tb/tb_pio_clkdiv_multi.sv | 121 ++++++++++++
 2 files changed

// File: rtl/pio_clkdiv_multi.sv
// pio_clkdiv_multi: NCH independent fractional clock dividers with shadowed divisor update; define PIO_CLKDIV_CLKOUT_EN for clk_out toggle flops
module pio_clkdiv_multi #(
  parameter int NCH = 4,
  parameter int INT_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NCH-1:0]          en,
  input  logic [NCH-1:0]          restart,
  input  logic [NCH-1:0]          div_load,
  input  logic [NCH*INT_W-1:0]    div_int,
  input  logic [NCH*FRAC_W-1:0]   div_frac,
  output logic [NCH-1:0]          penable,
  output logic [NCH-1:0]          update_pending,
  output logic [NCH-1:0]          clk_out
);
  localparam int AW = INT_W + FRAC_W + 1;
  localparam logic [AW-1:0] ONE = AW'(1) << FRAC_W;
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [INT_W-1:0] act_int, sh_int;
    logic [FRAC_W-1:0] act_frac, sh_frac;
    logic [AW-1:0] acc, d, s;
    logic hit, apply, pen, pend;
    // effective divisor (int 0 means 2^INT_W, int 1 forces 1.0) and the next accumulator step
    always_comb begin
      d = act_int == '0 ? {1'b1, act_int, act_frac} : act_int == INT_W'(1) ? ONE : {1'b0, act_int, act_frac};
      s = acc + ONE;
      hit = s >= d;
      apply = restart[i] | ~en[i] | hit;
    end
    // phase accumulator, pulse output and shadow-to-active divisor hand-off
    always_ff @(posedge clk) begin
      if (reset) begin
        acc <= '0;
        pen <= 1'b0;
        pend <= 1'b0;
        act_int <= INT_W'(1);
        act_frac <= '0;
        sh_int <= INT_W'(1);
        sh_frac <= '0;
      end else begin
        acc <= restart[i] ? '0 : !en[i] ? acc : hit ? s - d : s;
        pen <= !restart[i] && en[i] && hit;
        if (pend && apply) {act_int, act_frac} <= {sh_int, sh_frac};
        pend <= div_load[i] | (pend & ~apply);
        if (div_load[i]) {sh_int, sh_frac} <= {div_int[i*INT_W +: INT_W], div_frac[i*FRAC_W +: FRAC_W]};
      end
    end
    assign penable[i] = pen;
    assign update_pending[i] = pend;
`ifdef PIO_CLKDIV_CLKOUT_EN
    logic co;
    // square wave toggles on every pulse-producing edge; restart realigns it low
    always_ff @(posedge clk)
      co <= (reset || restart[i]) ? 1'b0 : co ^ (en[i] & hit);
    assign clk_out[i] = co;
`else
    assign clk_out[i] = 1'b0;
`endif
  end
endmodule

// File: tb/tb_pio_clkdiv_multi.sv
// tb_pio_clkdiv_multi: scoreboard bench for pio_clkdiv_multi
module tb_pio_clkdiv_multi;
  localparam int NCH = 4, IW = 16, FW = 8;
  logic clk = 1'b0, reset = 1'b1;
  logic [NCH-1:0] en = '0, restart = '0, div_load = '0;
  logic [NCH-1:0] penable, update_pending, clk_out;
  logic [NCH*IW-1:0] div_int = '0;
  logic [NCH*FW-1:0] div_frac = '0;
  logic [NCH-1:0] eco = '0;
  int checks = 0, failures = 0;
  typedef struct packed {logic [NCH-1:0] pen, pend, co;} exp_t;
  exp_t sb[$];

  pio_clkdiv_multi #(.NCH(NCH), .INT_W(IW), .FRAC_W(FW)) dut (
    .clk(clk), .reset(reset), .en(en), .restart(restart), .div_load(div_load),
    .div_int(div_int), .div_frac(div_frac), .penable(penable),
    .update_pending(update_pending), .clk_out(clk_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_div(input int c, input int vi, input int vf);
    div_int[c*IW +: IW] = IW'(vi);
    div_frac[c*FW +: FW] = FW'(vf);
    div_load[c] = 1'b1;
  endtask

  task automatic cyc(input string tag, input logic [NCH-1:0] ep, input logic [NCH-1:0] eu);
    exp_t e;
`ifdef PIO_CLKDIV_CLKOUT_EN
    eco = reset ? '0 : (eco ^ ep) & ~restart;
`endif
    e.pen = ep;
    e.pend = eu;
    e.co = eco;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, "_pen"}, 32'(penable), 32'(e.pen));
    chk({tag, "_pend"}, 32'(update_pending), 32'(e.pend));
    chk({tag, "_clkout"}, 32'(clk_out), 32'(e.co));
    restart = '0;
    div_load = '0;
  endtask

  initial begin
    cyc("rst", 4'b0, 4'b0);
    cyc("rst", 4'b0, 4'b0);
    reset = 1'b0;
    set_div(0, 4, 0);
    cyc("ld4", 4'b0, 4'b0001);
    cyc("ap4", 4'b0, 4'b0);
    en = 4'b0101;
    for (int k = 1; k <= 12; k++) cyc("div4", {1'b0, 1'b1, 1'b0, k % 4 == 0}, 4'b0);
    en = '0;
    cyc("idle", 4'b0, 4'b0);
    set_div(0, 2, 128);
    cyc("ld25", 4'b0, 4'b0001);
    restart[0] = 1'b1;
    cyc("rs25", 4'b0, 4'b0);
    en = 4'b0001;
    for (int k = 1; k <= 10; k++) cyc("div25", {3'b0, k == 3 || k == 5 || k == 8 || k == 10}, 4'b0);
    en = '0;
    set_div(0, 1, 200);
    cyc("ld1", 4'b0, 4'b0001);
    restart[0] = 1'b1;
    cyc("rs1", 4'b0, 4'b0);
    en = 4'b0001;
    for (int k = 1; k <= 5; k++) cyc("div1", 4'b0001, 4'b0);
    en = '0;
    set_div(0, 0, 0);
    cyc("ld0", 4'b0, 4'b0001);
    restart[0] = 1'b1;
    cyc("rs0", 4'b0, 4'b0);
    en = 4'b0001;
    for (int k = 1; k <= 65536; k++) cyc("divmax", {3'b0, k == 65536}, 4'b0);
    en = '0;
    set_div(0, 3, 0);
    set_div(1, 3, 0);
    cyc("ld3", 4'b0, 4'b0011);
    restart = 4'b0011;
    cyc("rs3", 4'b0, 4'b0);
    en = 4'b0001;
    cyc("skew", 4'b0, 4'b0);
    cyc("skew", 4'b0, 4'b0);
    en = 4'b0011;
    cyc("skew", 4'b0001, 4'b0);
    restart = 4'b0011;
    cyc("rsync", 4'b0, 4'b0);
    for (int k = 1; k <= 6; k++) cyc("sync", k % 3 == 0 ? 4'b0011 : 4'b0000, 4'b0);
    en = '0;
    set_div(0, 4, 0);
    cyc("ld4b", 4'b0, 4'b0001);
    restart[0] = 1'b1;
    cyc("rs4b", 4'b0, 4'b0);
    en = 4'b0001;
    for (int k = 1; k <= 12; k++) begin
      if (k == 4 || k == 6) set_div(0, 2, 0);
      if (k == 5) set_div(0, 3, 0);
      cyc("shadow", {3'b0, k == 4 || k == 8 || k == 10 || k == 12}, {3'b0, k >= 4 && k <= 7});
    end
    set_div(0, 5, 0);
    cyc("mid", 4'b0, 4'b0001);
    reset = 1'b1;
    cyc("midrst", 4'b0, 4'b0);
    cyc("midrst", 4'b0, 4'b0);
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) cyc("postrst", 4'b0001, 4'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
